cv32e40p_fetch_fifo_ft: RTL and testbench

Fault-tolerant prefetch FIFO that sits on the producer side of the fetch handshake. It buffers 32-bit instruction words returned by the instruction memory interface and presents them to the aligner on the fetch_valid/fetch_rdata/ready interface. Read pointer, write pointer and occupancy count are each stored as three copies; each copy is majority-voted and scrubbed every cycle. Error status is reported to the core's FT breakage logic.

---
 rtl/cv32e40p_fetch_fifo_ft.sv | 125 ++++++++++++
 tb/tb_cv32e40p_fetch_fifo_ft.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_fetch_fifo_ft.sv
// Prefetch FIFO with triplicated, voted and scrubbed rd_ptr/wr_ptr/count; one-cycle push-to-head latency.
// Optional per-entry even parity on stored words when FETCH_FIFO_PARITY_EN is defined.
module cv32e40p_fetch_fifo_ft #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_rdata_i,
  output logic             in_ready_o,
  output logic             fetch_valid_o,
  output logic [31:0]      fetch_rdata_o,
  input  logic             fetch_ready_i,
  output logic [PTR_W:0]   count_o,
  output logic             err_detected_o,
  output logic             err_corrected_o
);

  localparam int CW = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("cv32e40p_fetch_fifo_ft: DEPTH must be a power of two and at least 2");
  end

  // Bitwise 2-of-3; when all three disagree pairwise, copy 0 is taken as-is
  function automatic logic [PTR_W-1:0] vote_ptr(input logic [PTR_W-1:0] a,
                                               input logic [PTR_W-1:0] b,
                                               input logic [PTR_W-1:0] c);
    if (a != b && a != c && b != c) return a;
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [CW-1:0] vote_cnt(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic [CW-1:0] c);
    if (a != b && a != c && b != c) return a;
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [PTR_W-1:0] rd_ptr_q0, rd_ptr_q1, rd_ptr_q2;
  logic [PTR_W-1:0] wr_ptr_q0, wr_ptr_q1, wr_ptr_q2;
  logic [CW-1:0]    count_q0, count_q1, count_q2;

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CW-1:0]    count, count_n;
  logic             full, empty, push, pop;
  logic             rd_det, rd_unc, wr_det, wr_unc, cnt_det, cnt_unc;
  logic             par_err;

  logic [31:0]      mem [DEPTH];

  assign rd_ptr = vote_ptr(rd_ptr_q0, rd_ptr_q1, rd_ptr_q2);
  assign wr_ptr = vote_ptr(wr_ptr_q0, wr_ptr_q1, wr_ptr_q2);
  assign count  = vote_cnt(count_q0, count_q1, count_q2);

  assign rd_det  = (rd_ptr_q0 != rd_ptr_q1) || (rd_ptr_q0 != rd_ptr_q2);
  assign rd_unc  = (rd_ptr_q0 != rd_ptr_q1) && (rd_ptr_q0 != rd_ptr_q2) && (rd_ptr_q1 != rd_ptr_q2);
  assign wr_det  = (wr_ptr_q0 != wr_ptr_q1) || (wr_ptr_q0 != wr_ptr_q2);
  assign wr_unc  = (wr_ptr_q0 != wr_ptr_q1) && (wr_ptr_q0 != wr_ptr_q2) && (wr_ptr_q1 != wr_ptr_q2);
  assign cnt_det = (count_q0 != count_q1) || (count_q0 != count_q2);
  assign cnt_unc = (count_q0 != count_q1) && (count_q0 != count_q2) && (count_q1 != count_q2);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign in_ready_o    = !full;
  assign fetch_valid_o = !empty;
  assign fetch_rdata_o = fetch_valid_o ? mem[rd_ptr] : '0;
  assign count_o       = count;

  assign push = in_valid_i & in_ready_o & !flush_i;
  assign pop  = fetch_valid_o & fetch_ready_i & !flush_i;

  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    if (flush_i) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      if (push && !pop)      count_n = count + CW'(1);
      else if (pop && !push) count_n = count - CW'(1);
    end
  end

  // Every copy reloads the single voted next value, repairing any lone upset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q0 <= '0; rd_ptr_q1 <= '0; rd_ptr_q2 <= '0;
      wr_ptr_q0 <= '0; wr_ptr_q1 <= '0; wr_ptr_q2 <= '0;
      count_q0  <= '0; count_q1  <= '0; count_q2  <= '0;
    end else begin
      rd_ptr_q0 <= rd_ptr_n; rd_ptr_q1 <= rd_ptr_n; rd_ptr_q2 <= rd_ptr_n;
      wr_ptr_q0 <= wr_ptr_n; wr_ptr_q1 <= wr_ptr_n; wr_ptr_q2 <= wr_ptr_n;
      count_q0  <= count_n;  count_q1  <= count_n;  count_q2  <= count_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_rdata_i;
  end

`ifdef FETCH_FIFO_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk) begin
    if (push) par_q[wr_ptr] <= ^in_rdata_i;
  end

  assign par_err = fetch_valid_o && ((^mem[rd_ptr]) != par_q[rd_ptr]);
`else
  assign par_err = 1'b0;
`endif

  // Parity errors are detect-only; correction reflects pointer/count voting alone
  assign err_detected_o  = rd_det | wr_det | cnt_det | par_err;
  assign err_corrected_o = (rd_det | wr_det | cnt_det) & !(rd_unc | wr_unc | cnt_unc);

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ft.sv
// Randomized bench for cv32e40p_fetch_fifo_ft against a queue model; fault cases force state copies.
module tb_cv32e40p_fetch_fifo_ft;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, fetch_ready;
  logic [31:0] in_rdata;
  logic        in_ready, fetch_valid, err_det, err_corr;
  logic [31:0] fetch_rdata;
  logic [2:0]  count;

  logic [1:0]  fv_a, fv_b;
  logic [2:0]  fv_c;
  logic        fv_p;

  int vecs = 0;
  int errs = 0;
  logic [31:0] q[$];

  cv32e40p_fetch_fifo_ft #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_rdata_i(in_rdata), .in_ready_o(in_ready),
    .fetch_valid_o(fetch_valid), .fetch_rdata_o(fetch_rdata), .fetch_ready_i(fetch_ready),
    .count_o(count), .err_detected_o(err_det), .err_corrected_o(err_corr)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit can_push, can_pop;
    if (rst || flush) begin
      q.delete();
      return;
    end
    can_push = in_valid && (q.size() < DEPTH);
    can_pop  = fetch_ready && (q.size() > 0);
    if (can_pop) void'(q.pop_front());
    if (can_push) q.push_back(in_rdata);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; fetch_ready = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); in_rdata = '0;
    repeat (2) @(negedge clk);
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    vecs++; if (in_ready !== 1'b1 || fetch_valid !== 1'b0) begin
      errs++; $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, fetch_valid); end
    vecs++; if (fetch_rdata !== 32'h0 || err_det !== 1'b0 || err_corr !== 1'b0) begin
      errs++; $display("FAIL reset_misc got rdata=%h det=%b corr=%b exp 0", fetch_rdata, err_det, err_corr); end
    rst = 0;
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_basic();
    fetch_ready = 0;
    in_valid = 1; in_rdata = 32'h0000_0013; tick();
    in_rdata = 32'h0041_0093; tick();
    in_valid = 0;
    vecs++; if (count !== 3'd2) begin errs++; $display("FAIL basic_count got=%0d exp=2", count); end
    vecs++; if (fetch_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b exp=1", fetch_valid); end
    vecs++; if (fetch_rdata !== 32'h0000_0013) begin errs++; $display("FAIL basic_rdata got=%h exp=00000013", fetch_rdata); end
    vecs++; if (err_det !== 1'b0) begin errs++; $display("FAIL basic_err got=%b exp=0", err_det); end
    fetch_ready = 1; tick();
    vecs++; if (fetch_rdata !== 32'h0041_0093) begin errs++; $display("FAIL basic_second got=%h exp=00410093", fetch_rdata); end
    tick(); fetch_ready = 0;
    vecs++; if (fetch_valid !== 1'b0) begin errs++; $display("FAIL basic_drain got=%b exp=0", fetch_valid); end
  endtask

  task automatic test_full();
    logic [31:0] w [DEPTH];
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = $urandom; in_valid = 1; in_rdata = w[i]; tick();
    end
    vecs++; if (in_ready !== 1'b0 || count !== 3'd4) begin
      errs++; $display("FAIL full_flag got rdy=%b cnt=%0d exp rdy=0 cnt=4", in_ready, count); end
    in_rdata = 32'hDEAD_BEEF; tick();
    in_valid = 0;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL full_drop_count got=%0d exp=4", count); end
    fetch_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      vecs++; if (fetch_rdata !== w[i]) begin errs++; $display("FAIL full_order[%0d] got=%h exp=%h", i, fetch_rdata, w[i]); end
      tick();
    end
    fetch_ready = 0;
    vecs++; if (fetch_valid !== 1'b0 || count !== 3'd0) begin
      errs++; $display("FAIL full_empty got vld=%b cnt=%0d exp vld=0 cnt=0", fetch_valid, count); end
  endtask

  task automatic test_stream();
    logic [31:0] s;
    idle();
    in_valid = 1; fetch_ready = 1;
    for (int i = 0; i < 10; i++) begin
      s = $urandom; in_rdata = s; tick();
      vecs++; if (count !== 3'd1 || fetch_rdata !== s) begin
        errs++; $display("FAIL stream[%0d] got cnt=%0d rdata=%h exp cnt=1 rdata=%h", i, count, fetch_rdata, s); end
    end
    in_valid = 0; tick(); fetch_ready = 0;
    vecs++; if (fetch_valid !== 1'b0) begin errs++; $display("FAIL stream_end got=%b exp=0", fetch_valid); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_rdata = $urandom; tick(); end
    flush = 1; in_valid = 1; in_rdata = 32'hBADC_0DE5; fetch_ready = 1; tick();
    idle();
    vecs++; if (count !== 3'd0 || fetch_valid !== 1'b0 || fetch_rdata !== 32'h0) begin
      errs++; $display("FAIL flush_state got cnt=%0d vld=%b rdata=%h exp 0/0/0", count, fetch_valid, fetch_rdata); end
    tick(); tick();
    vecs++; if (fetch_valid !== 1'b0) begin errs++; $display("FAIL flush_stay got=%b exp=0", fetch_valid); end
    in_valid = 1; in_rdata = 32'h1234_5678; tick(); idle();
    vecs++; if (fetch_rdata !== 32'h1234_5678 || count !== 3'd1) begin
      errs++; $display("FAIL flush_refill got rdata=%h cnt=%0d exp 12345678/1", fetch_rdata, count); end
    fetch_ready = 1; tick(); idle();
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      fetch_ready = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      in_rdata    = $urandom;
      exp_d = (q.size() > 0) ? q[0] : 32'h0;
      vecs++;
      if (fetch_valid !== (q.size() > 0) || fetch_rdata !== exp_d || count !== 3'(q.size())
          || in_ready !== (q.size() < DEPTH) || err_det !== 1'b0) begin
        errs++;
        $display("FAIL random[%0d] got vld=%b rdata=%h cnt=%0d rdy=%b det=%b exp vld=%b rdata=%h cnt=%0d",
                 n, fetch_valid, fetch_rdata, count, in_ready, err_det, q.size() > 0, exp_d, q.size());
      end
      tick();
    end
    idle(); fetch_ready = 1;
    repeat (DEPTH) tick();
    idle();
  endtask

  task automatic test_seu();
    idle();
    in_valid = 1; in_rdata = 32'hA5A5_0001; tick();
    in_rdata = 32'hA5A5_0002; tick(); idle();
    fv_a = dut.rd_ptr_q0 ^ 2'b01;
    force dut.rd_ptr_q1 = fv_a;
    #1;
    vecs++; if (err_det !== 1'b1 || err_corr !== 1'b1) begin
      errs++; $display("FAIL seu_rd_flags got det=%b corr=%b exp 1/1", err_det, err_corr); end
    vecs++; if (fetch_rdata !== q[0] || count !== 3'(q.size())) begin
      errs++; $display("FAIL seu_rd_data got rdata=%h cnt=%0d exp %h/%0d", fetch_rdata, count, q[0], q.size()); end
    release dut.rd_ptr_q1;
    tick();
    vecs++; if (err_det !== 1'b0 || err_corr !== 1'b0) begin
      errs++; $display("FAIL seu_scrub got det=%b corr=%b exp 0/0", err_det, err_corr); end
    vecs++; if (fetch_rdata !== q[0]) begin errs++; $display("FAIL seu_after got=%h exp=%h", fetch_rdata, q[0]); end
    fv_c = dut.count_q0 ^ 3'b100;
    force dut.count_q2 = fv_c;
    #1;
    vecs++; if (err_det !== 1'b1 || err_corr !== 1'b1 || count !== 3'(q.size())) begin
      errs++; $display("FAIL seu_cnt got det=%b corr=%b cnt=%0d exp 1/1/%0d", err_det, err_corr, count, q.size()); end
    release dut.count_q2;
    tick();
    vecs++; if (err_det !== 1'b0 || count !== 3'(q.size())) begin
      errs++; $display("FAIL seu_cnt_scrub got det=%b cnt=%0d exp 0/%0d", err_det, count, q.size()); end
  endtask

  task automatic test_uncorrectable();
    idle();
    fv_a = dut.wr_ptr_q0 ^ 2'b01;
    fv_b = dut.wr_ptr_q0 ^ 2'b10;
    force dut.wr_ptr_q1 = fv_a;
    force dut.wr_ptr_q2 = fv_b;
    #1;
    vecs++; if (err_det !== 1'b1 || err_corr !== 1'b0) begin
      errs++; $display("FAIL unc_flags got det=%b corr=%b exp 1/0", err_det, err_corr); end
    release dut.wr_ptr_q1;
    release dut.wr_ptr_q2;
    tick();
    vecs++; if (err_det !== 1'b0 || err_corr !== 1'b0) begin
      errs++; $display("FAIL unc_scrub got det=%b corr=%b exp 0/0", err_det, err_corr); end
    fetch_ready = 1;
    while (q.size() > 0) tick();
    idle();
  endtask

  task automatic test_mid_reset();
    idle();
    in_valid = 1; in_rdata = $urandom; tick();
    in_rdata = $urandom; tick(); idle();
    #2 rst = 1;
    #1;
    vecs++; if (count !== 3'd0 || fetch_valid !== 1'b0 || in_ready !== 1'b1 || fetch_rdata !== 32'h0 || err_det !== 1'b0) begin
      errs++; $display("FAIL midrst got cnt=%0d vld=%b rdy=%b rdata=%h det=%b exp 0/0/1/0/0",
                       count, fetch_valid, in_ready, fetch_rdata, err_det); end
    q.delete();
    @(negedge clk); rst = 0;
    tick();
    vecs++; if (fetch_valid !== 1'b0 || count !== 3'd0) begin
      errs++; $display("FAIL midrst_after got vld=%b cnt=%0d exp 0/0", fetch_valid, count); end
  endtask

`ifdef FETCH_FIFO_PARITY_EN
  task automatic test_parity();
    idle();
    in_valid = 1; in_rdata = 32'h0000_0007; tick(); idle();
    vecs++; if (err_det !== 1'b0) begin errs++; $display("FAIL par_clean got=%b exp=0", err_det); end
    fv_p = 1'b0;
    force dut.par_q[0] = fv_p;
    #1;
    vecs++; if (err_det !== 1'b1 || err_corr !== 1'b0 || fetch_rdata !== 32'h0000_0007) begin
      errs++; $display("FAIL par_err got det=%b corr=%b rdata=%h exp 1/0/00000007", err_det, err_corr, fetch_rdata); end
    release dut.par_q[0];
    fetch_ready = 1; tick(); idle();
    vecs++; if (err_det !== 1'b0) begin errs++; $display("FAIL par_gone got=%b exp=0", err_det); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_flush();
    test_random();
    test_seu();
    test_uncorrectable();
    test_mid_reset();
`ifdef FETCH_FIFO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
